echo_request_m2p: RTL and testbench

ECHO_REQUEST_M2P -- requirements
Module: echo_request_m2p

---
 rtl/echo_request_m2p.sv | 106 ++++++++++
 tb/tb_echo_request_m2p.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/echo_request_m2p.sv
// Method-to-pipe request encoder: each accepted method call becomes one 128-bit
// message that is queued in a small circular buffer and drained onto the pipe.
module echo_request_m2p #(
  parameter int DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         method_say__ENA,
  input  logic [31:0]                  method_say_v,
  input  logic                         method_say2__ENA,
  input  logic [15:0]                  method_say2_a,
  input  logic [15:0]                  method_say2_b,
  input  logic                         method_setLeds__ENA,
  input  logic [7:0]                   method_setLeds_v,
  input  logic                         method_zsay4__ENA,
  output logic                         method_say__RDY,
  output logic                         method_say2__RDY,
  output logic                         method_setLeds__RDY,
  output logic                         method_zsay4__RDY,
  output logic                         pipe_enq__ENA,
  output logic [127:0]                 pipe_enq_v,
  input  logic                         pipe_enq__RDY,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         collision
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [127:0]  mem_q [DEPTH];
  logic [127:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          collision_q, collision_d;

  logic          rdy;
  logic          any_ena;
  logic          multi_ena;
  logic          push;
  logic          pop;
  logic [127:0]  msg;

  always_comb begin
    rdy       = (count_q != FULL);
    any_ena   = method_say__ENA | method_say2__ENA | method_setLeds__ENA | method_zsay4__ENA;
    multi_ena = (method_say__ENA & (method_say2__ENA | method_setLeds__ENA | method_zsay4__ENA))
              | (method_say2__ENA & (method_setLeds__ENA | method_zsay4__ENA))
              | (method_setLeds__ENA & method_zsay4__ENA);
    push      = rdy & any_ena;
    pop       = (count_q != '0) & pipe_enq__RDY;

    // Fixed priority: say > say2 > setLeds > zsay4.
    if (method_say__ENA)
      msg = {64'd0, method_say_v, 16'd0, 16'd2};
    else if (method_say2__ENA)
      msg = {64'd0, method_say2_b, method_say2_a, 16'd1, 16'd2};
    else if (method_setLeds__ENA)
      msg = {88'd0, method_setLeds_v, 16'd2, 16'd2};
    else
      msg = {96'd0, 16'd3, 16'd1};

    mem_d = mem_q;
    if (push)
      mem_d[wr_ptr_q] = msg;

    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    collision_d = collision_q | (push & multi_ena);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      collision_q <= collision_d;
    end
  end

  // The head entry is read straight from storage so the pipe never sees method inputs.
  assign pipe_enq_v          = mem_q[rd_ptr_q];
  assign pipe_enq__ENA       = pop;
  assign method_say__RDY     = rdy;
  assign method_say2__RDY    = rdy;
  assign method_setLeds__RDY = rdy;
  assign method_zsay4__RDY   = rdy;
  assign count               = count_q;
  assign collision           = collision_q;

endmodule

// File: tb/tb_echo_request_m2p.sv
// Directed and randomized checks of echo_request_m2p against a queue-based model.
module tb_echo_request_m2p;

  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          say_ena = 1'b0, say2_ena = 1'b0, leds_ena = 1'b0, z_ena = 1'b0;
  logic [31:0]   say_v = '0;
  logic [15:0]   s2_a = '0, s2_b = '0;
  logic [7:0]    leds_v = '0;
  logic          say_rdy, say2_rdy, leds_rdy, z_rdy;
  logic          enq_ena, enq_rdy = 1'b0;
  logic [127:0]  enq_v;
  logic [CW-1:0] cnt;
  logic          coll;

  int n_checks = 0;
  int n_fail = 0;

  logic [127:0] mq[$];
  logic         m_coll = 1'b0;

  echo_request_m2p #(.DEPTH(DEPTH)) dut (
    .CLK                 (clk),
    .nRST                (nrst),
    .method_say__ENA     (say_ena),
    .method_say_v        (say_v),
    .method_say2__ENA    (say2_ena),
    .method_say2_a       (s2_a),
    .method_say2_b       (s2_b),
    .method_setLeds__ENA (leds_ena),
    .method_setLeds_v    (leds_v),
    .method_zsay4__ENA   (z_ena),
    .method_say__RDY     (say_rdy),
    .method_say2__RDY    (say2_rdy),
    .method_setLeds__RDY (leds_rdy),
    .method_zsay4__RDY   (z_rdy),
    .pipe_enq__ENA       (enq_ena),
    .pipe_enq_v          (enq_v),
    .pipe_enq__RDY       (enq_rdy),
    .count               (cnt),
    .collision           (coll)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] enc_say(input logic [31:0] v);
    logic [127:0] m;
    m = '0;
    m[15:0]  = 16'd2;
    m[31:16] = 16'd0;
    m[63:32] = v;
    return m;
  endfunction

  function automatic logic [127:0] enc_say2(input logic [15:0] a, input logic [15:0] b);
    logic [127:0] m;
    m = '0;
    m[15:0]  = 16'd2;
    m[31:16] = 16'd1;
    m[47:32] = a;
    m[63:48] = b;
    return m;
  endfunction

  function automatic logic [127:0] enc_leds(input logic [7:0] v);
    logic [127:0] m;
    m = '0;
    m[15:0]  = 16'd2;
    m[31:16] = 16'd2;
    m[39:32] = v;
    return m;
  endfunction

  function automatic logic [127:0] enc_z();
    logic [127:0] m;
    m = '0;
    m[15:0]  = 16'd1;
    m[31:16] = 16'd3;
    return m;
  endfunction

  // One clock cycle: drive at negedge, check outputs against the model, advance the model.
  task automatic cyc(input logic e_say, input logic e_s2, input logic e_leds, input logic e_z,
                     input logic p_rdy, input logic [31:0] sv, input logic [15:0] a,
                     input logic [15:0] b, input logic [7:0] lv);
    logic         room, exp_pop;
    int           n_en;
    logic [127:0] m;
    @(negedge clk);
    say_ena = e_say; say2_ena = e_s2; leds_ena = e_leds; z_ena = e_z;
    enq_rdy = p_rdy; say_v = sv; s2_a = a; s2_b = b; leds_v = lv;
    #1;
    room    = (mq.size() != DEPTH);
    exp_pop = (mq.size() != 0) && p_rdy;
    chk("enq_ena", 128'(enq_ena), 128'(exp_pop));
    if (mq.size() != 0) chk("enq_v", enq_v, mq[0]);
    chk("rdy", 128'({say_rdy, say2_rdy, leds_rdy, z_rdy}), 128'({4{room}}));
    chk("count", 128'(cnt), 128'(mq.size()));
    chk("collision", 128'(coll), 128'(m_coll));
    n_en = int'(e_say) + int'(e_s2) + int'(e_leds) + int'(e_z);
    if (e_say)       m = enc_say(sv);
    else if (e_s2)   m = enc_say2(a, b);
    else if (e_leds) m = enc_leds(lv);
    else             m = enc_z();
    if (exp_pop) void'(mq.pop_front());
    if (room && n_en > 0) begin
      mq.push_back(m);
      if (n_en > 1) m_coll = 1'b1;
    end
  endtask

  task automatic idle(input logic p_rdy);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, p_rdy, '0, '0, '0, '0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ena", 128'(enq_ena), 128'd0);
    chk("rst_v", enq_v, 128'd0);
    chk("rst_rdy", 128'({say_rdy, say2_rdy, leds_rdy, z_rdy}), 128'hF);
    chk("rst_count", 128'(cnt), 128'd0);
    chk("rst_coll", 128'(coll), 128'd0);
    @(negedge clk);
    nrst = 1'b1;

    // say DEADBEEF with pipe ready
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, '0, '0, '0);
    idle(1'b1);
    chk("say_ena", 128'(enq_ena), 128'd1);
    chk("say_v", enq_v, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0002);
    idle(1'b1);
    chk("say_cnt0", 128'(cnt), 128'd0);

    // say2 then zsay4 with pipe stalled; fill to DEPTH, third request ignored
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 16'h1234, 16'h5678, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11111111, '0, '0, '0);
    chk("full_cnt", 128'(cnt), 128'd2);
    chk("full_rdy", 128'({say_rdy, say2_rdy, leds_rdy, z_rdy}), 128'h0);
    idle(1'b1);
    chk("s2_v", enq_v, 128'h0000_0000_0000_0000_5678_1234_0001_0002);
    idle(1'b1);
    chk("z_v", enq_v, 128'h0000_0000_0000_0000_0000_0000_0003_0001);
    idle(1'b1);
    chk("drain_ena", 128'(enq_ena), 128'd0);

    // setLeds and say together: say wins, collision sticks
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, '0, '0, 8'h77);
    idle(1'b0);
    chk("coll_cnt", 128'(cnt), 128'd1);
    chk("coll_flag", 128'(coll), 128'd1);
    chk("coll_v", enq_v, 128'h0000_0000_0000_0000_CAFE_F00D_0000_0002);
    idle(1'b1);
    idle(1'b1);
    chk("coll_hold", 128'(coll), 128'd1);

    // Streaming setLeds A5 at count=1 with pipe ready
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, '0, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, '0, 8'hA5);
      chk("stream_cnt", 128'(cnt), 128'd1);
      chk("stream_v", enq_v, 128'h0000_0000_0000_0000_0000_00A5_0002_0002);
    end
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset mid-cycle with a full buffer
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hAAAA5555, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    idle(1'b1);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_ena", 128'(enq_ena), 128'd0);
    chk("arst_v", enq_v, 128'd0);
    chk("arst_cnt", 128'(cnt), 128'd0);
    chk("arst_coll", 128'(coll), 128'd0);
    mq.delete();
    m_coll = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0, '0);
    idle(1'b1);
    chk("post_rst_v", enq_v, 128'h0000_0000_0000_0000_0000_0000_0003_0001);
    idle(1'b1);
    chk("post_rst_once", 128'(enq_ena), 128'd0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 20),
          ($urandom_range(0, 99) < 65), $urandom, 16'($urandom), 16'($urandom),
          8'($urandom));
      chk("rand_cnt_range", 128'(cnt <= CW'(DEPTH)), 128'd1);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("rand_drained", 128'(cnt), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
